inst_fifo_dual: RTL and testbench

Dual-ported instruction queue between the fetch stage and the dual-issue decode stage. It is the producing end of the master/slave decode slots that feed the ID/EX pipeline register. Each cycle it accepts up to two fetched instructions (pc, inst, fetch address-error flag). It presents the two oldest entries as the master and slave decode slots, and retires 0, 1 or 2 entries according to what decode actually issued.

---
 rtl/inst_fifo_dual.sv | 103 ++++++++++
 tb/tb_inst_fifo_dual.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fifo_dual.sv
// Dual-ported instruction queue between fetch and dual-issue decode.
// Accepts up to two entries per cycle, presents the two oldest as master/slave slots.
module inst_fifo_dual #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          write_en1,
  input  logic          write_en2,
  input  logic [31:0]   write_pc1,
  input  logic [31:0]   write_pc2,
  input  logic [31:0]   write_inst1,
  input  logic [31:0]   write_inst2,
  input  logic          write_adel1,
  input  logic          write_adel2,
  input  logic          read_en1,
  input  logic          read_en2,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          master_valid,
  output logic          slave_valid,
  output logic [31:0]   master_pc,
  output logic [31:0]   master_inst,
  output logic          master_adel,
  output logic [31:0]   slave_pc,
  output logic [31:0]   slave_inst,
  output logic          slave_adel
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;
  logic [AW-1:0] head_p1, tail_p1;
  logic [1:0]    push_amt, pop_req;
  logic [AW:0]   pop_amt;
  entry_t        master_e, slave_e;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q > (AW+1)'(DEPTH - 2));
  assign master_valid = (count_q >= (AW+1)'(1));
  assign slave_valid  = (count_q >= (AW+1)'(2));

  always_comb begin
    push_amt = 2'd0;
    // A push while full is dropped as a whole; write_en2 alone is ignored.
    if (write_en1 && !full) begin
      push_amt = write_en2 ? 2'd2 : 2'd1;
    end
    pop_req = 2'd0;
    if (read_en1) begin
      pop_req = read_en2 ? 2'd2 : 2'd1;
    end
    pop_amt = ((AW+1)'(pop_req) > count_q) ? count_q : (AW+1)'(pop_req);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(pop_amt);
      tail_q  <= tail_q + AW'(push_amt);
      count_q <= count_q + (AW+1)'(push_amt) - pop_amt;
    end
  end

  // Storage is intentionally not cleared; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_amt != 2'd0) begin
      mem[tail_q] <= '{pc: write_pc1, inst: write_inst1, adel: write_adel1};
      if (push_amt == 2'd2) begin
        mem[tail_p1] <= '{pc: write_pc2, inst: write_inst2, adel: write_adel2};
      end
    end
  end

  always_comb begin
    master_e = master_valid ? mem[head_q]  : '0;
    slave_e  = slave_valid  ? mem[head_p1] : '0;
  end

  assign master_pc   = master_e.pc;
  assign master_inst = master_e.inst;
  assign master_adel = master_e.adel;
  assign slave_pc    = slave_e.pc;
  assign slave_inst  = slave_e.inst;
  assign slave_adel  = slave_e.adel;

endmodule

// File: tb/tb_inst_fifo_dual.sv
// Directed bench for inst_fifo_dual (DEPTH=16): reset, push/pop mixes, full, wrap, flush.
module tb_inst_fifo_dual;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          write_en1, write_en2;
  logic [31:0]   write_pc1, write_pc2, write_inst1, write_inst2;
  logic          write_adel1, write_adel2;
  logic          read_en1, read_en2;
  logic          full, empty;
  logic [AW:0]   count;
  logic          master_valid, slave_valid;
  logic [31:0]   master_pc, master_inst, slave_pc, slave_inst;
  logic          master_adel, slave_adel;

  int vectors     = 0;
  int miscompares = 0;

  inst_fifo_dual #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .write_en1(write_en1), .write_en2(write_en2),
    .write_pc1(write_pc1), .write_pc2(write_pc2),
    .write_inst1(write_inst1), .write_inst2(write_inst2),
    .write_adel1(write_adel1), .write_adel2(write_adel2),
    .read_en1(read_en1), .read_en2(read_en2),
    .full(full), .empty(empty), .count(count),
    .master_valid(master_valid), .slave_valid(slave_valid),
    .master_pc(master_pc), .master_inst(master_inst), .master_adel(master_adel),
    .slave_pc(slave_pc), .slave_inst(slave_inst), .slave_adel(slave_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; write_en1 = 0; write_en2 = 0;
    write_pc1 = 0; write_pc2 = 0; write_inst1 = 0; write_inst2 = 0;
    write_adel1 = 0; write_adel2 = 0; read_en1 = 0; read_en2 = 0;
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later. Inst word is ~pc.
  task automatic cyc(input logic we1, input logic we2, input logic [31:0] pc1,
                     input logic [31:0] pc2, input logic a2, input logic re1,
                     input logic re2, input logic fl);
    write_en1 = we1; write_en2 = we2;
    write_pc1 = pc1; write_pc2 = pc2;
    write_inst1 = ~pc1; write_inst2 = ~pc2;
    write_adel1 = 1'b0; write_adel2 = a2;
    read_en1 = re1; read_en2 = re2; flush = fl;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;

    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_mvalid", 32'(master_valid), 32'd0);
    chk("rst_svalid", 32'(slave_valid), 32'd0);
    chk("rst_mpc", master_pc, 32'h0);
    chk("rst_sinst", slave_inst, 32'h0);

    // Idle must change nothing.
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_count", 32'(count), 32'd0);

    cyc(1, 1, 32'hBFC0_0000, 32'hBFC0_0004, 0, 0, 0, 0);
    chk("pair_count", 32'(count), 32'd2);
    chk("pair_mpc", master_pc, 32'hBFC0_0000);
    chk("pair_spc", slave_pc, 32'hBFC0_0004);
    chk("pair_minst", master_inst, 32'h403F_FFFF);
    chk("pair_mvalid", 32'(master_valid), 32'd1);
    chk("pair_svalid", 32'(slave_valid), 32'd1);
    chk("pair_empty", 32'(empty), 32'd0);

    // write_en2 alone is ignored
    cyc(0, 1, 32'hBAD0_0000, 32'hBAD0_0004, 0, 0, 0, 0);
    chk("we2only_count", 32'(count), 32'd2);

    cyc(1, 0, 32'hBFC0_0008, 32'h0, 0, 0, 0, 0);
    chk("single_count", 32'(count), 32'd3);
    chk("single_mpc", master_pc, 32'hBFC0_0000);

    // count=3: double push + single pop
    cyc(1, 1, 32'hBFC0_000C, 32'hBFC0_0010, 0, 1, 0, 0);
    chk("pushpop_count", 32'(count), 32'd4);
    chk("pushpop_mpc", master_pc, 32'hBFC0_0004);
    chk("pushpop_spc", slave_pc, 32'hBFC0_0008);

    // head=1 tail=5; five pairs fill indices 5..14
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 32'h2000 + 32'(8 * i), 32'h2004 + 32'(8 * i), 0, 0, 0, 0);
    end
    chk("c14_count", 32'(count), 32'd14);
    chk("c14_full", 32'(full), 32'd0);

    // Pair at tail=15: entry 2 wraps to index 0
    cyc(1, 1, 32'h100, 32'h104, 1, 0, 0, 0);
    chk("c16_count", 32'(count), 32'd16);
    chk("c16_full", 32'(full), 32'd1);

    // Dropped push must not overwrite live index 1 (current master)
    cyc(1, 1, 32'hDEAD_0000, 32'hDEAD_0004, 0, 0, 0, 0);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_mpc", master_pc, 32'hBFC0_0004);
    chk("drop_spc", slave_pc, 32'hBFC0_0008);

    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    chk("dpop_count", 32'(count), 32'd14);
    chk("dpop_full", 32'(full), 32'd0);
    chk("dpop_mpc", master_pc, 32'hBFC0_000C);
    chk("dpop_spc", slave_pc, 32'hBFC0_0010);

    // head 3 -> 13
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 1, 0);
    chk("h13_count", 32'(count), 32'd4);
    chk("h13_mpc", master_pc, 32'h2020);
    chk("h13_spc", slave_pc, 32'h2024);

    // head 15: slave read wraps to index 0
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    chk("wrap_count", 32'(count), 32'd2);
    chk("wrap_mpc", master_pc, 32'h100);
    chk("wrap_spc", slave_pc, 32'h104);
    chk("wrap_sinst", slave_inst, 32'hFFFF_FEFB);
    chk("wrap_madel", 32'(master_adel), 32'd0);
    chk("wrap_sadel", 32'(slave_adel), 32'd1);

    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("c1_count", 32'(count), 32'd1);
    chk("c1_mpc", master_pc, 32'h104);
    chk("c1_svalid", 32'(slave_valid), 32'd0);
    chk("c1_spc", slave_pc, 32'h0);

    // count=1 with double read: only one pops
    cyc(0, 0, 0, 0, 0, 1, 1, 0);
    chk("clip_count", 32'(count), 32'd0);
    chk("clip_empty", 32'(empty), 32'd1);
    chk("clip_mpc", master_pc, 32'h0);

    // read at empty: no pop, head stays at 1
    cyc(0, 0, 0, 0, 0, 1, 0, 0);
    chk("uflow_count", 32'(count), 32'd0);
    cyc(1, 0, 32'h300, 32'h0, 0, 0, 0, 0);
    chk("p300_count", 32'(count), 32'd1);
    chk("p300_mpc", master_pc, 32'h300);

    cyc(1, 1, 32'h304, 32'h308, 0, 0, 0, 0);
    cyc(1, 1, 32'h30C, 32'h310, 0, 0, 0, 0);
    chk("c5_count", 32'(count), 32'd5);

    // Flush beats simultaneous push and pop
    cyc(1, 1, 32'h400, 32'h404, 0, 1, 0, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_mvalid", 32'(master_valid), 32'd0);

    cyc(1, 0, 32'h200, 32'h0, 0, 0, 0, 0);
    chk("p200_mpc", master_pc, 32'h200);
    chk("p200_count", 32'(count), 32'd1);
    chk("p200_svalid", 32'(slave_valid), 32'd0);

    // Mid-operation reset with an in-flight push
    rst = 1;
    cyc(1, 1, 32'h500, 32'h504, 0, 0, 0, 0);
    rst = 0;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_mpc", master_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
